uart_tx_drain: RTL and testbench

//   Serial UART transmitter that sits directly downstream of the byte FIFO.
//   It pops words from the FIFO read port (out/get/empty) and shifts each one
//   out as an asynchronous serial frame: start bit, data LSB first, optional

---
 rtl/uart_tx_drain.sv | 123 ++++++++++++
 tb/tb_uart_tx_drain.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_drain
// Description : UART transmitter that drains a show-ahead FIFO read port and
//               shifts each word out as start, data (LSB first), parity, stop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_drain #(
    parameter int W      = 8,
    parameter int DIV    = 16,
    parameter int STOP   = 1,
    parameter int PARITY = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] in,
    input  logic         empty,
    output logic         get,
    output logic         tx,
    output logic         busy
);

    localparam int TW = $clog2(DIV);
    localparam int BW = $clog2(W + 1);

    localparam logic [TW-1:0] c_TMAX  = TW'(DIV - 1);
    localparam logic [BW-1:0] c_BLAST = BW'(W - 1);
    localparam logic [BW-1:0] c_SLAST = BW'(STOP - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_PAR   = 3'd3;
    localparam logic [2:0] c_STOP  = 3'd4;

    logic [2:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [BW-1:0] r_bitcnt;
    logic [W-1:0]  r_shift;
    logic          r_par;
    logic          r_tx;

    logic          w_tick;
    logic          w_stop_end;
    logic [W-1:0]  w_shift_nx;

    assign w_tick     = (r_timer == '0);
    assign w_stop_end = (r_state == c_STOP) && w_tick && (r_bitcnt == c_SLAST);
    assign w_shift_nx = r_shift >> 1;

    // Popping in the final stop cycle lets the next start bit follow with no gap.
    assign get  = en & ~empty & ~reset & ((r_state == c_IDLE) | w_stop_end);
    assign tx   = r_tx;
    assign busy = (r_state != c_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_timer  <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_tx     <= 1'b1;
        end else if (get) begin
            r_shift  <= in;
            r_par    <= (PARITY == 2) ? ~^in : ^in;
            r_state  <= c_START;
            r_timer  <= c_TMAX;
            r_bitcnt <= '0;
            r_tx     <= 1'b0;
        end else if (r_state != c_IDLE) begin
            if (!w_tick) begin
                r_timer <= r_timer - 1'b1;
            end else begin
                r_timer <= c_TMAX;
                case (r_state)
                    c_START: begin
                        r_state  <= c_DATA;
                        r_bitcnt <= '0;
                        r_tx     <= r_shift[0];
                    end
                    c_DATA: begin
                        if (r_bitcnt == c_BLAST) begin
                            r_bitcnt <= '0;
                            if (PARITY != 0) begin
                                r_state <= c_PAR;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= c_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                            r_shift  <= w_shift_nx;
                            r_tx     <= w_shift_nx[0];
                        end
                    end
                    c_PAR: begin
                        r_state  <= c_STOP;
                        r_bitcnt <= '0;
                        r_tx     <= 1'b1;
                    end
                    c_STOP: begin
                        if (w_stop_end) begin
                            r_state <= c_IDLE;
                            r_timer <= '0;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                        r_tx <= 1'b1;
                    end
                    default: begin
                        r_state <= c_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_drain
// Description : Scoreboard bench for uart_tx_drain (W=8, DIV=4, STOP=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_drain;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] in0;
    logic       empty0;
    logic [7:0] in_p;
    logic       empty_p;
    logic       get0, tx0, busy0;
    logic       get1, tx1, busy1;
    logic       get2, tx2, busy2;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;

    logic [7:0]  fifo0[$];
    logic [15:0] exp0[$];
    logic [15:0] exp1[$];
    logic [15:0] exp2[$];
    int          stamps[$];

    uart_tx_drain #(.W(8), .DIV(4), .STOP(1), .PARITY(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .in(in0), .empty(empty0),
        .get(get0), .tx(tx0), .busy(busy0));
    uart_tx_drain #(.W(8), .DIV(4), .STOP(1), .PARITY(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .in(in_p), .empty(empty_p),
        .get(get1), .tx(tx1), .busy(busy1));
    uart_tx_drain #(.W(8), .DIV(4), .STOP(1), .PARITY(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .in(in_p), .empty(empty_p),
        .get(get2), .tx(tx2), .busy(busy2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push0(input logic [7:0] b);
        fifo0.push_back(b);
        in0    = fifo0[0];
        empty0 = 1'b0;
    endtask

    // One clock: sample the pop strobe, let the edge happen, model the FIFO pop.
    task automatic tick();
        logic g;
        #1;
        g = get0;
        if (g) stamps.push_back(cyc);
        @(posedge clk);
        cyc++;
        #1;
        if (g && fifo0.size() > 0) void'(fifo0.pop_front());
        in0    = (fifo0.size() > 0) ? fifo0[0] : 8'h00;
        empty0 = (fifo0.size() == 0);
        @(negedge clk);
    endtask

    task automatic measure(output int cnt);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (busy0) cnt++;
            else if (cnt > 0) break;
        end
    endtask

    function automatic logic txof(input int id);
        case (id)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    // Decodes each frame cycle by cycle; every bit must hold for exactly 4 cycles.
    task automatic monitor(input int id);
        int          nb;
        logic [15:0] frm;
        logic [15:0] e;
        bit          ok;
        bit          abort;
        bit          have;
        nb = (id == 0) ? 10 : 11;
        forever begin
            @(posedge clk);
            #3;
            if (reset || txof(id)) continue;
            frm   = '0;
            ok    = 1'b1;
            abort = 1'b0;
            for (int b = 0; b < nb && !abort; b++) begin
                for (int c = 0; c < 4 && !abort; c++) begin
                    if (!(b == 0 && c == 0)) begin
                        @(posedge clk);
                        #3;
                        if (reset) abort = 1'b1;
                        else if (c == 0) frm[b] = txof(id);
                        else if (txof(id) != frm[b]) ok = 1'b0;
                    end
                end
            end
            if (!abort) begin
                have = 1'b0;
                e    = '0;
                case (id)
                    0: if (exp0.size() > 0) begin e = exp0.pop_front(); have = 1'b1; end
                    1: if (exp1.size() > 0) begin e = exp1.pop_front(); have = 1'b1; end
                    default: if (exp2.size() > 0) begin e = exp2.pop_front(); have = 1'b1; end
                endcase
                n_checks++;
                if (!have || !ok || frm != e) begin
                    n_fail++;
                    $display("FAIL frame dut%0d: got %0h (steady=%0d), expected %0h (queued=%0d)",
                             id, frm, ok, e, have);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    initial begin
        int cnt, c1, c2, n0;
        reset   = 1'b1;
        en      = 1'b1;
        in0     = 8'h00;
        empty0  = 1'b1;
        in_p    = 8'h07;
        empty_p = 1'b1;

        // Reset held with a byte waiting: nothing may pop or transmit.
        push0(8'hA5);
        exp0.push_back(16'h034A);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_get", {31'b0, get0}, 32'd0);
            chk("reset_tx", {31'b0, tx0}, 32'd1);
            chk("reset_busy", {31'b0, busy0}, 32'd0);
        end

        // Single byte 0xA5.
        reset = 1'b0;
        #1;
        chk("pop_after_reset", {31'b0, get0}, 32'd1);
        n0 = stamps.size();
        measure(cnt);
        chk("single_busy_len", cnt, 32'd40);
        chk("single_get_count", stamps.size() - n0, 32'd1);

        // Back-to-back 0x00 then 0xFF.
        push0(8'h00);
        push0(8'hFF);
        exp0.push_back(16'h0200);
        exp0.push_back(16'h03FE);
        n0 = stamps.size();
        measure(cnt);
        chk("b2b_busy_len", cnt, 32'd80);
        chk("b2b_get_count", stamps.size() - n0, 32'd2);
        if (stamps.size() >= n0 + 2)
            chk("b2b_get_gap", stamps[n0+1] - stamps[n0], 32'd40);
        else
            chk("b2b_get_gap", 32'd0, 32'd40);

        // Parity: byte 0x07 -> even parity 1, odd parity 0.
        exp1.push_back(16'h060E);
        exp2.push_back(16'h040E);
        empty_p = 1'b0;
        #1;
        chk("par_even_get", {31'b0, get1}, 32'd1);
        chk("par_odd_get", {31'b0, get2}, 32'd1);
        tick();
        empty_p = 1'b1;
        c1 = busy1 ? 1 : 0;
        c2 = busy2 ? 1 : 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (busy1) c1++;
            if (busy2) c2++;
            if (!busy1 && !busy2) break;
        end
        chk("par_even_len", c1, 32'd44);
        chk("par_odd_len", c2, 32'd44);

        // en dropped mid-frame: frame completes, then the line holds idle.
        push0(8'h5A);
        push0(8'hC3);
        exp0.push_back(16'h02B4);
        exp0.push_back(16'h0386);
        for (int i = 0; i < 10; i++) tick();
        en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!busy0) break;
        end
        chk("en_frame_done", {31'b0, busy0}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("en_hold_get", {31'b0, get0}, 32'd0);
            chk("en_hold_tx", {31'b0, tx0}, 32'd1);
        end
        en = 1'b1;
        #1;
        chk("en_resume_get", {31'b0, get0}, 32'd1);
        measure(cnt);
        chk("en_resume_len", cnt, 32'd40);

        // Reset during DATA bit 3 of 0x91 (bit 3 = 0); 0x3C must follow intact.
        push0(8'h91);
        push0(8'h3C);
        exp0.push_back(16'h0278);
        for (int i = 0; i < 18; i++) tick();
        chk("mid_bit3_tx", {31'b0, tx0}, 32'd0);
        chk("mid_bit3_busy", {31'b0, busy0}, 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_reset_tx", {31'b0, tx0}, 32'd1);
        chk("mid_reset_busy", {31'b0, busy0}, 32'd0);
        chk("mid_reset_get", {31'b0, get0}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_reset_get", {31'b0, get0}, 32'd1);
        measure(cnt);
        chk("post_reset_len", cnt, 32'd40);

        for (int i = 0; i < 5; i++) tick();
        chk("sb0_drained", exp0.size(), 32'd0);
        chk("sb1_drained", exp1.size(), 32'd0);
        chk("sb2_drained", exp2.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
